// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid buffer
// for responses that arrive under stall, and branch redirect with response draining.
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        stall_core_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] fetch_instruction_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] skid_instr;
    logic [31:0] skid_instr_nxt;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc_nxt;
    logic        skid_full;
    logic        skid_full_nxt;
    logic [31:0] out_instr_nxt;
    logic [31:0] out_pc_nxt;
    logic        out_valid_nxt;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic [31:0] redirect_pc;

    assign redirect_pc = branch_target_i & ~32'h3;
    assign imem_req_o  = (state == S_REQ);
    assign imem_addr_o = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        skid_full_nxt  = skid_full;
        out_instr_nxt  = fetch_instruction_o;
        out_pc_nxt     = fetch_pc_o;
        out_valid_nxt  = fetch_valid_o;
        deliver        = 1'b0;
        deliver_instr  = NOP_INSTR;
        deliver_pc     = pc;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (branch_taken_i) begin
                    state_nxt = imem_gnt_i ? S_DRAIN : S_REQ;
                end else if (imem_gnt_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken_i) begin
                    state_nxt = imem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    if (stall_core_i) begin
                        skid_instr_nxt = imem_rdata_i;
                        skid_pc_nxt    = pc;
                        skid_full_nxt  = 1'b1;
                        state_nxt      = S_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata_i;
                        deliver_pc    = pc;
                        state_nxt     = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken_i) begin
                    skid_full_nxt = 1'b0;
                    state_nxt     = S_REQ;
                end else if (!stall_core_i && skid_full) begin
                    deliver       = 1'b1;
                    deliver_instr = skid_instr;
                    deliver_pc    = skid_pc;
                    skid_full_nxt = 1'b0;
                    state_nxt     = S_REQ;
                end
            end
            S_DRAIN: begin
                // The in-flight response belongs to the old path; once it lands the
                // channel is free, even if a new redirect arrives in the same cycle.
                if (imem_rvalid_i) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (branch_taken_i) begin
            pc_nxt        = redirect_pc;
            out_instr_nxt = NOP_INSTR;
            out_valid_nxt = 1'b0;
        end else if (deliver) begin
            pc_nxt        = pc + 32'd4;
            out_instr_nxt = deliver_instr;
            out_pc_nxt    = deliver_pc;
            out_valid_nxt = 1'b1;
        end else if (!stall_core_i) begin
            out_instr_nxt = NOP_INSTR;
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state               <= S_IDLE;
            pc                  <= RESET_PC;
            skid_instr          <= NOP_INSTR;
            skid_pc             <= RESET_PC;
            skid_full           <= 1'b0;
            fetch_instruction_o <= NOP_INSTR;
            fetch_pc_o          <= RESET_PC;
            fetch_valid_o       <= 1'b0;
        end else begin
            state               <= state_nxt;
            pc                  <= pc_nxt;
            skid_instr          <= skid_instr_nxt;
            skid_pc             <= skid_pc_nxt;
            skid_full           <= skid_full_nxt;
            fetch_instruction_o <= out_instr_nxt;
            fetch_pc_o          <= out_pc_nxt;
            fetch_valid_o       <= out_valid_nxt;
        end
    end

endmodule

`default_nettype wire
